// File: rtl/test_status_pkg.sv
// Shared definitions for the test status monitor: verdict encoding, state type, default counter width.
package test_status_pkg;

    localparam int unsigned CNT_W_DEFAULT = 32;

    localparam logic [1:0] VERDICT_RUNNING = 2'b00;
    localparam logic [1:0] VERDICT_PASS    = 2'b01;
    localparam logic [1:0] VERDICT_FAIL    = 2'b10;
    localparam logic [1:0] VERDICT_TIMEOUT = 2'b11;

    // State codes equal the verdict codes so the state register drives verdict directly.
    typedef enum logic [1:0] {
        ST_RUNNING   = VERDICT_RUNNING,
        ST_PASSED    = VERDICT_PASS,
        ST_FAILED    = VERDICT_FAIL,
        ST_TIMED_OUT = VERDICT_TIMEOUT
    } state_t;

endpackage

// File: rtl/test_status_monitor_sat_counter.sv
// Saturating up-counter with enable and asynchronous active-low clear.
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/test_status_monitor.sv
// Run-time / check-pulse monitor producing a sticky PASS, FAIL or TIMEOUT verdict.
// Define TEST_STATUS_REPORT_EN to compile in simulation-only reporting and auto-$finish.
module test_status_monitor
    import test_status_pkg::*;
#(
    parameter string       PREFIX  = "TEST",
    parameter int unsigned TIMEOUT = 100000,
    parameter int unsigned CNT_W   = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pass,
    input  logic             fail,
    output logic             done,
    output logic [1:0]       verdict,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] pass_count,
    output logic [CNT_W-1:0] fail_count
);

    state_t state;
    state_t state_nx;
    logic   running_c;
    logic   timeout_hit_c;

    // State register; done is registered alongside so it rises with the verdict.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_RUNNING;
            done  <= 1'b0;
        end else begin
            state <= state_nx;
            done  <= (state_nx != ST_RUNNING);
        end
    end

    // Next state: fail beats pass beats timeout.
    always_comb begin
        state_nx      = state;
        running_c     = (state == ST_RUNNING);
        timeout_hit_c = (TIMEOUT != 0) && (cycle_count == CNT_W'(TIMEOUT - 1));
        if (running_c) begin
            if (fail) begin
                state_nx = ST_FAILED;
            end else if (pass) begin
                state_nx = ST_PASSED;
            end else if (timeout_hit_c) begin
                state_nx = ST_TIMED_OUT;
            end
        end
    end

    assign verdict = state;

    sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk   (clk),
        .rst_n (reset),
        .en    (running_c),
        .count (cycle_count)
    );

    sat_counter #(.W(CNT_W)) u_pass_cnt (
        .clk   (clk),
        .rst_n (reset),
        .en    (running_c & pass),
        .count (pass_count)
    );

    sat_counter #(.W(CNT_W)) u_fail_cnt (
        .clk   (clk),
        .rst_n (reset),
        .en    (running_c & fail),
        .count (fail_count)
    );

`ifdef TEST_STATUS_REPORT_EN
    logic       reported;
    logic [3:0] finish_cnt;

    // Reports once on reaching a verdict, then ends the simulation 10 cycles after done rose.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            reported   <= 1'b0;
            finish_cnt <= '0;
        end else begin
            if (running_c && fail) begin
                $display("%s: check failed at cycle %0d", PREFIX, cycle_count);
            end
            if (done && !reported) begin
                reported   <= 1'b1;
                finish_cnt <= 4'd1;
                case (state)
                    ST_PASSED: $display("%s: TEST PASSED", PREFIX);
                    ST_FAILED: $display("%s: TEST FAILED", PREFIX);
                    default:   $display("%s: TEST TIMEOUT", PREFIX);
                endcase
                $display("%s: cycle_count=%0d pass_count=%0d fail_count=%0d",
                         PREFIX, cycle_count, pass_count, fail_count);
            end else if (reported) begin
                if (finish_cnt == 4'd9) begin
                    $finish;
                end else begin
                    finish_cnt <= finish_cnt + 4'd1;
                end
            end
        end
    end
`else
    // Reporting compiled out; the synthesizable behaviour is unchanged.
`endif

endmodule

// File: tb/tb_test_status_monitor.sv
// Self-checking bench: five monitor instances (various TIMEOUT/CNT_W) share stimulus and are compared to a reference model.
module tb_test_status_monitor;

    localparam int unsigned N = 5;
    localparam longint unsigned TO [N] = '{64'd20, 64'd100, 64'd10, 64'd0, 64'd0};
    localparam longint unsigned MX [N] = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFF,
                                           64'hFFFF_FFFF, 64'd15};

    logic        clk;
    logic        reset;
    logic        pass;
    logic        fail;
    logic        a_done [N];
    logic [1:0]  a_v    [N];
    logic [31:0] a_cyc  [N];
    logic [31:0] a_pc   [N];
    logic [31:0] a_fc   [N];
    logic [3:0]  c4_cyc;
    logic [3:0]  c4_pc;
    logic [3:0]  c4_fc;

    int unsigned     m_v   [N];
    longint unsigned m_cyc [N];
    longint unsigned m_pc  [N];
    longint unsigned m_fc  [N];

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        p;
        logic        f;
        logic [1:0]  v;
        logic        d;
        int unsigned cyc;
        int unsigned pc;
        int unsigned fc;
    } vec_t;

    vec_t tbl [12];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    test_status_monitor #(.PREFIX("T20"), .TIMEOUT(20)) u_t20 (
        .clk(clk), .reset(reset), .pass(pass), .fail(fail),
        .done(a_done[0]), .verdict(a_v[0]), .cycle_count(a_cyc[0]),
        .pass_count(a_pc[0]), .fail_count(a_fc[0]));

    test_status_monitor #(.PREFIX("T100"), .TIMEOUT(100)) u_t100 (
        .clk(clk), .reset(reset), .pass(pass), .fail(fail),
        .done(a_done[1]), .verdict(a_v[1]), .cycle_count(a_cyc[1]),
        .pass_count(a_pc[1]), .fail_count(a_fc[1]));

    test_status_monitor #(.PREFIX("T10"), .TIMEOUT(10)) u_t10 (
        .clk(clk), .reset(reset), .pass(pass), .fail(fail),
        .done(a_done[2]), .verdict(a_v[2]), .cycle_count(a_cyc[2]),
        .pass_count(a_pc[2]), .fail_count(a_fc[2]));

    test_status_monitor #(.PREFIX("T0"), .TIMEOUT(0)) u_t0 (
        .clk(clk), .reset(reset), .pass(pass), .fail(fail),
        .done(a_done[3]), .verdict(a_v[3]), .cycle_count(a_cyc[3]),
        .pass_count(a_pc[3]), .fail_count(a_fc[3]));

    test_status_monitor #(.PREFIX("SAT"), .TIMEOUT(0), .CNT_W(4)) u_sat (
        .clk(clk), .reset(reset), .pass(pass), .fail(fail),
        .done(a_done[4]), .verdict(a_v[4]), .cycle_count(c4_cyc),
        .pass_count(c4_pc), .fail_count(c4_fc));

    assign a_cyc[4] = 32'(c4_cyc);
    assign a_pc[4]  = 32'(c4_pc);
    assign a_fc[4]  = 32'(c4_fc);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < N; i++) begin
            m_v[i]   = 0;
            m_cyc[i] = 0;
            m_pc[i]  = 0;
            m_fc[i]  = 0;
        end
    endtask

    // One clock of the spec's rules: counting while running, then fail > pass > budget used up.
    task automatic model_edge(input logic p, input logic f);
        longint unsigned elapsed;
        for (int i = 0; i < N; i++) begin
            if (m_v[i] == 0) begin
                elapsed  = m_cyc[i] + 1;
                m_cyc[i] = (elapsed > MX[i]) ? MX[i] : elapsed;
                if (p && m_pc[i] < MX[i]) m_pc[i] = m_pc[i] + 1;
                if (f && m_fc[i] < MX[i]) m_fc[i] = m_fc[i] + 1;
                if (f)                                m_v[i] = 2;
                else if (p)                           m_v[i] = 1;
                else if (TO[i] != 0 && elapsed == TO[i]) m_v[i] = 3;
            end
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < N; i++) begin
            chk($sformatf("u%0d.done", i),    64'(a_done[i]), 64'(m_v[i] != 0));
            chk($sformatf("u%0d.verdict", i), 64'(a_v[i]),    64'(m_v[i]));
            chk($sformatf("u%0d.cycle", i),   64'(a_cyc[i]),  m_cyc[i]);
            chk($sformatf("u%0d.pass_cnt", i), 64'(a_pc[i]),  m_pc[i]);
            chk($sformatf("u%0d.fail_cnt", i), 64'(a_fc[i]),  m_fc[i]);
        end
    endtask

    // Called at a falling edge: drive inputs, advance model, sample at the next falling edge.
    task automatic step(input logic p, input logic f);
        pass = p;
        fail = f;
        model_edge(p, f);
        @(negedge clk);
        check_all();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        pass  = 1'b0;
        fail  = 1'b0;
        clear_model();
        #1 check_all();
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0);
    endtask

    initial begin
        // Vectors for the TIMEOUT=10 instance: fail lands on the last budget cycle, later pulses ignored.
        for (int k = 0; k < 9; k++) tbl[k] = '{1'b0, 1'b0, 2'b00, 1'b0, k + 1, 0, 0};
        tbl[9]  = '{1'b0, 1'b1, 2'b10, 1'b1, 10, 0, 1};
        tbl[10] = '{1'b1, 1'b0, 2'b10, 1'b1, 10, 0, 1};
        tbl[11] = '{1'b1, 1'b1, 2'b10, 1'b1, 10, 0, 1};

        reset = 1'b1;
        pass  = 1'b0;
        fail  = 1'b0;
        #1;
        do_reset();
        chk("reset.done", 64'(a_done[2]), 64'd0);
        chk("reset.verdict", 64'(a_v[2]), 64'd0);

        // Table-driven: fail exactly at cycle TIMEOUT-1
        for (int k = 0; k < 12; k++) begin
            step(tbl[k].p, tbl[k].f);
            chk($sformatf("tbl%0d.verdict", k),  64'(a_v[2]),    64'(tbl[k].v));
            chk($sformatf("tbl%0d.done", k),     64'(a_done[2]), 64'(tbl[k].d));
            chk($sformatf("tbl%0d.cycle", k),    64'(a_cyc[2]),  64'(tbl[k].cyc));
            chk($sformatf("tbl%0d.pass_cnt", k), 64'(a_pc[2]),   64'(tbl[k].pc));
            chk($sformatf("tbl%0d.fail_cnt", k), 64'(a_fc[2]),   64'(tbl[k].fc));
        end

        // Idle timeout with TIMEOUT=20
        do_reset();
        idle(19);
        chk("to20.done_early", 64'(a_done[0]), 64'd0);
        chk("to20.cycle_early", 64'(a_cyc[0]), 64'd19);
        idle(1);
        chk("to20.done", 64'(a_done[0]), 64'd1);
        chk("to20.verdict", 64'(a_v[0]), 64'd3);
        chk("to20.cycle", 64'(a_cyc[0]), 64'd20);
        idle(2);
        chk("to20.cycle_hold", 64'(a_cyc[0]), 64'd20);

        // Pass at cycle 5, later fail ignored
        do_reset();
        idle(5);
        step(1'b1, 1'b0);
        chk("pass5.verdict", 64'(a_v[1]), 64'd1);
        chk("pass5.cycle", 64'(a_cyc[1]), 64'd6);
        chk("pass5.pass_cnt", 64'(a_pc[1]), 64'd1);
        idle(3);
        step(1'b0, 1'b1);
        chk("pass5.fail_ignored", 64'(a_fc[1]), 64'd0);
        chk("pass5.verdict_hold", 64'(a_v[1]), 64'd1);

        // Simultaneous pass and fail at cycle 3
        do_reset();
        idle(3);
        step(1'b1, 1'b1);
        chk("both.verdict", 64'(a_v[1]), 64'd2);
        chk("both.pass_cnt", 64'(a_pc[1]), 64'd1);
        chk("both.fail_cnt", 64'(a_fc[1]), 64'd1);

        // TIMEOUT=0 runs forever; 4-bit instance saturates
        do_reset();
        idle(1000);
        chk("to0.done", 64'(a_done[3]), 64'd0);
        chk("to0.verdict", 64'(a_v[3]), 64'd0);
        chk("to0.cycle", 64'(a_cyc[3]), 64'd1000);
        chk("sat.cycle", 64'(a_cyc[4]), 64'd15);

        // Asynchronous reset in the middle of a FAILED run
        do_reset();
        idle(2);
        step(1'b0, 1'b1);
        idle(4);
        chk("midrst.pre_verdict", 64'(a_v[1]), 64'd2);
        #2 reset = 1'b0;
        clear_model();
        #1;
        chk("midrst.verdict", 64'(a_v[1]), 64'd0);
        chk("midrst.done", 64'(a_done[1]), 64'd0);
        chk("midrst.fail_cnt", 64'(a_fc[1]), 64'd0);
        check_all();
        @(negedge clk);
        reset = 1'b1;
        idle(3);
        chk("midrst.restart_cycle", 64'(a_cyc[1]), 64'd3);
        chk("midrst.restart_verdict", 64'(a_v[1]), 64'd0);

        // Randomized pulses against the model
        for (int r = 0; r < 6; r++) begin
            do_reset();
            for (int c = 0; c < 300; c++) begin
                step(($urandom_range(0, 39) == 0), ($urandom_range(0, 59) == 0));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
